// File: rtl/system_status_monitor.sv
// -----------------------------------------------------------------------------
// system_status_monitor
//
// Convergence monitor for the ONN neuron array. A start pulse begins a run;
// the monitor then watches the per-neuron state-change strobes and declares
// the array steady once no neuron has changed for STEADY_WIN consecutive
// sample ticks. If TIMEOUT clk cycles elapse first, the run is flagged
// inconsistent. During the phase-update window (full_tick=1) the monitor is
// frozen: neither counter advances and change strobes are ignored.
//
// Optional feature (macro SYSTEM_STATUS_CHANGE_COUNT_EN):
//   adds change_count, a saturating count of RUN cycles with a change.
//
// Ports:
//   clk            in   system clock, posedge
//   rst            in   asynchronous active-high reset
//   start          in   1-cycle pulse: clear flags/counters, begin a run
//   sample_tick    in   enable at neuron sample rate
//   full_tick      in   phase-update window; freezes the monitor
//   state_changed  in   [N_NEURONS] per-neuron change strobes
//   busy           out  run in progress
//   done           out  run ended (steady or inconsistent), sticky
//   steady         out  converged, sticky
//   inconsistent   out  timed out without convergence, sticky
//   settle_cycles  out  [CYC_W] clk cycles from start to end of run
//   change_count   out  [CNT_W] (optional) saturating change-cycle count
// -----------------------------------------------------------------------------
module system_status_monitor #(
  parameter int N_NEURONS  = 15,
  parameter int STEADY_WIN = 64,
  parameter int TIMEOUT    = 10000,
  parameter int CYC_W      = 21,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sample_tick,
  input  logic                 full_tick,
  input  logic [N_NEURONS-1:0] state_changed,
  output logic                 busy,
  output logic                 done,
  output logic                 steady,
  output logic                 inconsistent,
`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
  output logic [CYC_W-1:0]     settle_cycles,
  output logic [CNT_W-1:0]     change_count
`else
  output logic [CYC_W-1:0]     settle_cycles
`endif
);

  // quiet_cnt only needs to reach STEADY_WIN; it leaves RUN on that cycle.
  localparam int QW = $clog2(STEADY_WIN + 1);
  localparam logic [QW-1:0]    WIN = QW'(STEADY_WIN);
  localparam logic [CYC_W-1:0] TMO = CYC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEADY = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [QW-1:0]    quiet_cnt, quiet_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
  logic [CYC_W-1:0] settle_nxt;
  logic             chg;

  // A change strobe during the phase-update window is not a real change.
  assign chg = (|state_changed) & ~full_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      quiet_cnt     <= '0;
      cyc_cnt       <= '0;
      settle_cycles <= '0;
      busy          <= 1'b0;
      steady        <= 1'b0;
      inconsistent  <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      quiet_cnt     <= quiet_nxt;
      cyc_cnt       <= cyc_nxt;
      settle_cycles <= settle_nxt;
      busy          <= (state_nxt == S_RUN);
      steady        <= (state_nxt == S_STEADY);
      inconsistent  <= (state_nxt == S_FAIL);
      done          <= (state_nxt == S_STEADY) || (state_nxt == S_FAIL);
    end
  end

  always_comb begin
    state_nxt  = state;
    quiet_nxt  = quiet_cnt;
    cyc_nxt    = cyc_cnt;
    settle_nxt = settle_cycles;
    if (start) begin
      // start from any state, including a restart in the middle of a run
      state_nxt  = S_RUN;
      quiet_nxt  = '0;
      cyc_nxt    = '0;
      settle_nxt = '0;
    end else if (state == S_RUN && !full_tick) begin
      cyc_nxt = cyc_cnt + 1'b1;
      if (chg) begin
        quiet_nxt = '0;
      end else if (sample_tick) begin
        quiet_nxt = quiet_cnt + 1'b1;
      end
      // steady is tested first so it wins a coincident timeout
      if (quiet_nxt == WIN) begin
        state_nxt  = S_STEADY;
        settle_nxt = cyc_nxt;
      end else if (cyc_nxt == TMO) begin
        state_nxt  = S_FAIL;
        settle_nxt = cyc_nxt;
      end
    end
  end

`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change_count <= '0;
    end else if (start) begin
      change_count <= '0;
    end else if (state == S_RUN && chg && change_count != '1) begin
      change_count <= change_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_system_status_monitor.sv
module tb_system_status_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // dut_a: default parameters (CNT_W reduced to exercise saturation)
  logic        start_a = 0, tick_a = 0, full_a = 0;
  logic [14:0] chg_a = '0;
  logic        busy_a, done_a, steady_a, inc_a;
  logic [20:0] settle_a;

  // dut_b: STEADY_WIN=4, TIMEOUT=16, driven from the vector table
  logic        start_b = 0, tick_b = 0, full_b = 0;
  logic [3:0]  chg_b = '0;
  logic        busy_b, done_b, steady_b, inc_b;
  logic [4:0]  settle_b;

`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
  logic [3:0]  ccnt_a, ccnt_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  system_status_monitor #(
    .N_NEURONS(15), .STEADY_WIN(64), .TIMEOUT(10000), .CYC_W(21), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sample_tick(tick_a),
    .full_tick(full_a), .state_changed(chg_a), .busy(busy_a), .done(done_a),
    .steady(steady_a), .inconsistent(inc_a),
`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
    .settle_cycles(settle_a), .change_count(ccnt_a)
`else
    .settle_cycles(settle_a)
`endif
  );

  system_status_monitor #(
    .N_NEURONS(4), .STEADY_WIN(4), .TIMEOUT(16), .CYC_W(5), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sample_tick(tick_b),
    .full_tick(full_b), .state_changed(chg_b), .busy(busy_b), .done(done_b),
    .steady(steady_b), .inconsistent(inc_b),
`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
    .settle_cycles(settle_b), .change_count(ccnt_b)
`else
    .settle_cycles(settle_b)
`endif
  );

  typedef struct {
    logic start, tick, full, chg;
    logic busy, steady, inc;
    int   settle;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic s, logic t, logic f, logic c,
                              logic b, logic st, logic in, int se);
    vec_t v;
    v.start = s; v.tick = t; v.full = f; v.chg = c;
    v.busy = b; v.steady = st; v.inc = in; v.settle = se;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(string name, logic b, logic st, logic in, int se);
    chk({name, " busy"}, 32'(busy_a), 32'(b));
    chk({name, " steady"}, 32'(steady_a), 32'(st));
    chk({name, " inconsistent"}, 32'(inc_a), 32'(in));
    chk({name, " done"}, 32'(done_a), 32'(st | in));
    chk({name, " settle"}, 32'(settle_a), 32'(se));
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  initial begin
    // ---------------- vector table for dut_b ----------------
    add(1,0,0,0, 1,0,0,0);
    repeat (3) add(0,1,0,0, 1,0,0,0);
    add(0,1,0,0, 0,1,0,4);                 // 4th quiet tick -> steady
    add(0,1,0,1, 0,1,0,4);                 // terminal: inputs ignored
    add(1,0,0,0, 1,0,0,0);                 // start clears flags and settle
    add(0,1,0,1, 1,0,0,0);                 // change beats tick (cyc 1)
    add(0,1,1,1, 1,0,0,0);                 // frozen
    repeat (2) add(0,1,0,0, 1,0,0,0);      // cyc 2,3 quiet 1,2
    add(0,0,0,1, 1,0,0,0);                 // cyc 4 quiet 0
    repeat (8) add(0,0,0,0, 1,0,0,0);      // cyc 5..12
    repeat (3) add(0,1,0,0, 1,0,0,0);      // cyc 13..15 quiet 1..3
    add(0,1,0,0, 0,1,0,16);                // steady and timeout together
    add(1,0,0,0, 1,0,0,0);
    repeat (15) add(0,0,0,0, 1,0,0,0);     // cyc 1..15
    add(0,0,0,0, 0,0,1,16);                // timeout
    add(0,1,0,1, 0,0,1,16);                // terminal
    add(1,0,0,0, 1,0,0,0);
    repeat (2) add(0,1,0,0, 1,0,0,0);      // quiet 2
    add(1,0,0,0, 1,0,0,0);                 // restart discards quiet count
    repeat (3) add(0,1,0,0, 1,0,0,0);
    add(0,1,0,0, 0,1,0,4);

    // ---------------- reset ----------------
    step(); step();
    chk_a("reset_a", 0, 0, 0, 0);
    chk("reset_b busy", 32'(busy_b), 32'd0);
    chk("reset_b done", 32'(done_b), 32'd0);
    chk("reset_b settle", 32'(settle_b), 32'd0);
    rst = 1'b0;
    step();

    // ---------------- table-driven run on dut_b ----------------
    foreach (tbl[i]) begin
      start_b = tbl[i].start;
      tick_b  = tbl[i].tick;
      full_b  = tbl[i].full;
      chg_b   = tbl[i].chg ? 4'b0100 : 4'b0000;
      step();
      chk($sformatf("vec%0d busy", i), 32'(busy_b), 32'(tbl[i].busy));
      chk($sformatf("vec%0d steady", i), 32'(steady_b), 32'(tbl[i].steady));
      chk($sformatf("vec%0d inconsistent", i), 32'(inc_b), 32'(tbl[i].inc));
      chk($sformatf("vec%0d done", i), 32'(done_b),
          32'(tbl[i].steady | tbl[i].inc));
      chk($sformatf("vec%0d settle", i), 32'(settle_b), 32'(tbl[i].settle));
    end
    start_b = 0; tick_b = 0; full_b = 0; chg_b = '0;

    // ---------------- 1: quiet run, tick every 4 clk ----------------
    pulse_start_a();
    chk_a("t1 start", 1, 0, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      tick_a = (k % 4 == 0);
      step();
      if (k == 255) chk_a("t1 pre", 1, 0, 0, 0);
    end
    tick_a = 0;
    chk_a("t1 steady", 0, 1, 0, 256);

    // ---------------- 2: neuron 3 toggles every 50 clk -> timeout ----------------
    pulse_start_a();
    chk_a("t2 start", 1, 0, 0, 0);
    for (int k = 1; k <= 10000; k++) begin
      tick_a = (k % 4 == 0);
      chg_a  = (k % 50 == 0) ? 15'h0008 : 15'h0000;
      step();
      if (k == 9999) chk_a("t2 pre", 1, 0, 0, 0);
    end
    tick_a = 0; chg_a = '0;
    chk_a("t2 timeout", 0, 0, 1, 10000);

    // ---------------- 3: freeze window with strobes ----------------
    pulse_start_a();
    for (int k = 1; k <= 30; k++) begin
      tick_a = 1'b1;
      step();
    end
    full_a = 1'b1;
    chg_a  = '1;
    for (int k = 0; k < 1000; k++) begin
      tick_a = k[0];
      step();
    end
    full_a = 1'b0;
    chg_a  = '0;
    for (int k = 1; k <= 34; k++) begin
      tick_a = 1'b1;
      step();
      if (k == 33) chk_a("t3 pre", 1, 0, 0, 0);
    end
    tick_a = 0;
    chk_a("t3 steady", 0, 1, 0, 64);
`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
    chk("t3 change_count", 32'(ccnt_a), 32'd0);
`endif

    // ---------------- 5: restart at cycle 500, then rst ----------------
    pulse_start_a();
    for (int k = 1; k <= 499; k++) begin
      tick_a = (k <= 40);
      step();
    end
    tick_a = 0;
    chk_a("t5 before restart", 1, 0, 0, 0);
    pulse_start_a();
    chk_a("t5 restart", 1, 0, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      tick_a = 1'b1;
      step();
      if (k == 63) chk_a("t5 pre", 1, 0, 0, 0);
    end
    tick_a = 0;
    chk_a("t5 steady", 0, 1, 0, 64);
    #2 rst = 1'b1;
    #1 chk_a("t5 async rst terminal", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    pulse_start_a();
    repeat (20) step();
    chk_a("t5 running", 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_a("t5 async rst run", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk_a("t5 idle after rst", 0, 0, 0, 0);

`ifdef SYSTEM_STATUS_CHANGE_COUNT_EN
    // ---------------- 6: change_count saturation ----------------
    pulse_start_a();
    chg_a = 15'h0001;
    repeat (20) step();
    chg_a = '0;
    chk("t6 saturated", 32'(ccnt_a), 32'd15);
    pulse_start_a();
    chk("t6 cleared", 32'(ccnt_a), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
